thor_vec_agen: RTL and testbench

//  Parametrised, sequential successor to the scalar load/store address generator.

---
 rtl/thor_vec_agen_if.sv | 46 ++++
 rtl/thor_vec_agen.sv | 268 ++++++++++++++++++++++++++
 tb/tb_thor_vec_agen.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/thor_vec_agen_if.sv
// Command, index-fetch and address-beat bundle for thor_vec_agen.
// slave is the address generator's view, master is the issue/VRF/LSU side.
interface thor_vec_agen_if #(
    parameter int AWID   = 32,
    parameter int MAX_VL = 64,
    parameter int IWID   = 64,
    parameter int VLW    = $clog2(MAX_VL + 1)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [AWID-1:0]   cmd_base;
    logic [AWID-1:0]   cmd_disp;
    logic [AWID-1:0]   cmd_stride;
    logic [1:0]        cmd_esz;
    logic [1:0]        cmd_sc;
    logic [VLW-1:0]    cmd_vl;
    logic [MAX_VL-1:0] cmd_mask;
    logic [AWID-1:0]   cmd_lo;
    logic [AWID-1:0]   cmd_hi;
    logic              idx_req;
    logic [VLW-1:0]    idx_elem;
    logic              idx_valid;
    logic [IWID-1:0]   idx_data;
    logic              ea_valid;
    logic              ea_ready;
    logic [AWID-1:0]   ea;
    logic [VLW-1:0]    ea_elem;
    logic              ea_last;
    logic              abort;
    logic              busy;
    logic              done;
    logic              fault;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_base, cmd_disp, cmd_stride, cmd_esz, cmd_sc,
               cmd_vl, cmd_mask, cmd_lo, cmd_hi, idx_valid, idx_data, ea_ready, abort,
        output cmd_ready, idx_req, idx_elem, ea_valid, ea, ea_elem, ea_last, busy, done, fault
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_base, cmd_disp, cmd_stride, cmd_esz, cmd_sc,
               cmd_vl, cmd_mask, cmd_lo, cmd_hi, idx_valid, idx_data, ea_ready, abort,
        input  cmd_ready, idx_req, idx_elem, ea_valid, ea, ea_elem, ea_last, busy, done, fault
    );
endinterface

// File: rtl/thor_vec_agen.sv
// Sequential vector load/store address generator: one effective address per active element.
// Optional bounds check against [cmd_lo,cmd_hi] is enabled by defining THOR_VAGEN_BOUNDS_CHK_EN.
module thor_vec_agen #(
    parameter int AWID   = 32,
    parameter int MAX_VL = 64,
    parameter int IWID   = 64
) (
    input logic             clk,
    input logic             rst_n,
    thor_vec_agen_if.slave  bus
);
    localparam int VLW = $clog2(MAX_VL + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_IDX   = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        esz_q, esz_d;
    logic [1:0]        sc_q, sc_d;
    logic [AWID-1:0]   stride_q, stride_d;
    logic [AWID-1:0]   bd_q, bd_d;
    logic [AWID-1:0]   acc_q, acc_d;
    logic [AWID-1:0]   ea_q, ea_d;
    logic              ea_last_q, ea_last_d;
    logic              fault_q, fault_d;
    logic [VLW-1:0]    elem_q, elem_d;
    logic [MAX_VL-1:0] act_q, act_d;

    logic              accept_s;
    logic              abort_s;
    logic [VLW-1:0]    vl_eff_s;
    logic [AWID-1:0]   bd_cmd_s;
    logic [MAX_VL-1:0] act_cmd_s;
    logic [MAX_VL-1:0] act_sh_s;
    logic [AWID-1:0]   inc_s;
    logic [AWID-1:0]   idx_ea_s;
    logic              oob_cmd_s;
    logic              oob_acc_s;
    logic              oob_idx_s;

    function automatic logic [MAX_VL-1:0] vl_mask_f(input logic [VLW-1:0] vl);
        logic [MAX_VL-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_VL; k++) begin
            m[k] = (k < int'(vl)) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    assign accept_s  = (state_q == S_IDLE) && bus.cmd_valid && !bus.abort;
    assign abort_s   = (state_q != S_IDLE) && bus.abort;
    assign vl_eff_s  = (bus.cmd_vl > VLW'(MAX_VL)) ? VLW'(MAX_VL) : bus.cmd_vl;
    assign bd_cmd_s  = bus.cmd_base + bus.cmd_disp;
    assign act_cmd_s = bus.cmd_mask & vl_mask_f(vl_eff_s);
    // Bit 0 is the current element; anything above it is still pending.
    assign act_sh_s  = act_q >> elem_q;
    assign idx_ea_s  = bd_q + (AWID'($signed(bus.idx_data)) << sc_q);

    // Per-element address step; shift instead of multiply for unit stride.
    always_comb begin
        inc_s = '0;
        case (mode_q)
            2'd1:    inc_s = AWID'(1) << esz_q;
            2'd2:    inc_s = stride_q;
            default: inc_s = '0;
        endcase
    end

`ifdef THOR_VAGEN_BOUNDS_CHK_EN
    logic [AWID-1:0] lo_q, lo_d;
    logic [AWID-1:0] hi_q, hi_d;

    function automatic logic oob_f(input logic [AWID-1:0] a, input logic [AWID-1:0] lo,
                                   input logic [AWID-1:0] hi);
        return (a < lo) || (a > hi);
    endfunction

    // Bounds are captured with the command so later elements use the same window.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (accept_s) begin
            lo_d = bus.cmd_lo;
            hi_d = bus.cmd_hi;
        end else begin
            lo_d = lo_q;
            hi_d = hi_q;
        end
    end

    // Bounds window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign oob_cmd_s = oob_f(bd_cmd_s, bus.cmd_lo, bus.cmd_hi);
    assign oob_acc_s = oob_f(acc_q, lo_q, hi_q);
    assign oob_idx_s = oob_f(idx_ea_s, lo_q, hi_q);
    assign bus.fault = fault_q;
`else
    logic unused_bounds_s;
    assign unused_bounds_s = ^{bus.cmd_lo, bus.cmd_hi, fault_q};
    assign oob_cmd_s = 1'b0;
    assign oob_acc_s = 1'b0;
    assign oob_idx_s = 1'b0;
    assign bus.fault = 1'b0;
`endif

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        esz_d     = esz_q;
        sc_d      = sc_q;
        stride_d  = stride_q;
        bd_d      = bd_q;
        acc_d     = acc_q;
        ea_d      = ea_q;
        ea_last_d = ea_last_q;
        fault_d   = fault_q;
        elem_d    = elem_q;
        act_d     = act_q;
        if (abort_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        mode_d    = bus.cmd_mode;
                        esz_d     = bus.cmd_esz;
                        sc_d      = bus.cmd_sc;
                        stride_d  = bus.cmd_stride;
                        bd_d      = bd_cmd_s;
                        acc_d     = bd_cmd_s;
                        ea_d      = bd_cmd_s;
                        act_d     = act_cmd_s;
                        elem_d    = '0;
                        fault_d   = 1'b0;
                        ea_last_d = ((act_cmd_s >> 1) == '0);
                        // Element 0 is resolved here so an active first element issues at T+1.
                        if (bus.cmd_mode == 2'd0) begin
                            ea_last_d = 1'b1;
                            if (oob_cmd_s) begin
                                fault_d = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_ISSUE;
                            end
                        end else if (act_cmd_s[0]) begin
                            if (bus.cmd_mode == 2'd3) begin
                                state_d = S_IDX;
                            end else if (oob_cmd_s) begin
                                fault_d = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_ISSUE;
                            end
                        end else begin
                            state_d = S_SCAN;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SCAN: begin
                    ea_d      = acc_q;
                    ea_last_d = ((act_sh_s >> 1) == '0);
                    if (act_sh_s == '0) begin
                        state_d = S_DONE;
                    end else if (act_sh_s[0]) begin
                        if (mode_q == 2'd3) begin
                            state_d = S_IDX;
                        end else if (oob_acc_s) begin
                            fault_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        elem_d = elem_q + VLW'(1);
                        acc_d  = acc_q + inc_s;
                    end
                end
                S_IDX: begin
                    if (bus.idx_valid) begin
                        ea_d = idx_ea_s;
                        if (oob_idx_s) begin
                            fault_d = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        state_d = S_IDX;
                    end
                end
                S_ISSUE: begin
                    if (bus.ea_ready) begin
                        elem_d = elem_q + VLW'(1);
                        acc_d  = acc_q + inc_s;
                        if ((mode_q != 2'd0) && !ea_last_q) begin
                            state_d = S_SCAN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            esz_q     <= 2'd0;
            sc_q      <= 2'd0;
            stride_q  <= '0;
            bd_q      <= '0;
            acc_q     <= '0;
            ea_q      <= '0;
            ea_last_q <= 1'b0;
            fault_q   <= 1'b0;
            elem_q    <= '0;
            act_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            esz_q     <= esz_d;
            sc_q      <= sc_d;
            stride_q  <= stride_d;
            bd_q      <= bd_d;
            acc_q     <= acc_d;
            ea_q      <= ea_d;
            ea_last_q <= ea_last_d;
            fault_q   <= fault_d;
            elem_q    <= elem_d;
            act_q     <= act_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.idx_req   = (state_q == S_IDX);
    assign bus.idx_elem  = elem_q;
    assign bus.ea_valid  = (state_q == S_ISSUE);
    assign bus.ea        = ea_q;
    assign bus.ea_elem   = elem_q;
    assign bus.ea_last   = ea_last_q;
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_thor_vec_agen.sv
// Directed bench for thor_vec_agen: a beat-list model built from the command rules,
// checked every cycle by one compare process, plus hand-computed literal expectations.
module tb_thor_vec_agen;
    localparam int AWID    = 32;
    localparam int MAX_VL  = 64;
    localparam int IWID    = 64;
    localparam int IDX_LAT = 3;

    typedef struct {
        logic [31:0] ea;
        logic [6:0]  elem;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;

    thor_vec_agen_if #(.AWID(AWID), .MAX_VL(MAX_VL), .IWID(IWID)) ifc ();

    thor_vec_agen #(.AWID(AWID), .MAX_VL(MAX_VL), .IWID(IWID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    beat_t       exp_q[$];
    int          exp_idx_q[$];
    logic        exp_fault = 1'b0;
    logic [63:0] idx_val [MAX_VL];
    logic [31:0] got_ea [MAX_VL];
    int          got_elem [MAX_VL];
    int          got_n = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          idx_req_cyc = 0;
    int          acc_cyc = 0;
    logic        prev_stall = 1'b0;
    beat_t       prev_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Expected beats straight from the addressing rules (multiply form, not incremental).
    task automatic build_exp(input logic [1:0] mode, input logic [31:0] base, input logic [31:0] disp,
                             input logic [31:0] stride, input logic [1:0] esz, input logic [1:0] sc,
                             input int vl, input logic [63:0] mask,
                             input logic [31:0] lo, input logic [31:0] hi);
        logic [31:0] bd;
        logic [31:0] a;
        logic        bnd;
        int          n;
        int          last_e;
        exp_q.delete();
        exp_idx_q.delete();
        exp_fault   = 1'b0;
        got_n       = 0;
        first_cyc   = -1;
        idx_req_cyc = 0;
        bd = base + disp;
`ifdef THOR_VAGEN_BOUNDS_CHK_EN
        bnd = 1'b1;
`else
        bnd = 1'b0;
`endif
        if (mode == 2'd0) begin
            if (bnd && ((bd < lo) || (bd > hi))) exp_fault = 1'b1;
            else exp_q.push_back('{ea: bd, elem: 7'd0, last: 1'b1});
            return;
        end
        n = (vl > MAX_VL) ? MAX_VL : vl;
        last_e = -1;
        for (int e = 0; e < n; e++) if (mask[e]) last_e = e;
        for (int e = 0; e < n; e++) begin
            if (mask[e]) begin
                case (mode)
                    2'd1:    a = bd + 32'(e) * (32'd1 << esz);
                    2'd2:    a = bd + 32'(e) * stride;
                    default: begin
                        a = bd + (32'($signed(idx_val[e])) << sc);
                        exp_idx_q.push_back(e);
                    end
                endcase
                if (bnd && ((a < lo) || (a > hi))) begin
                    exp_fault = 1'b1;
                    break;
                end
                exp_q.push_back('{ea: a, elem: 7'(e), last: (e == last_e)});
            end
        end
    endtask

    // Single compare process: beats, stalls, index requests and completion.
    initial begin : compare
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(ifc.ea_valid), 64'd1);
                    chk("hold_ea", 64'(ifc.ea), 64'(prev_b.ea));
                    chk("hold_elem", 64'(ifc.ea_elem), 64'(prev_b.elem));
                    chk("hold_last", 64'(ifc.ea_last), 64'(prev_b.last));
                end
                prev_stall = ifc.ea_valid && !ifc.ea_ready && !ifc.abort;
                prev_b = '{ea: ifc.ea, elem: ifc.ea_elem, last: ifc.ea_last};
                if (ifc.ea_valid && ifc.ea_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL extra_beat: got ea 0x%0h elem %0d, expected no beat", ifc.ea, ifc.ea_elem);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_ea", 64'(ifc.ea), 64'(b.ea));
                        chk("beat_elem", 64'(ifc.ea_elem), 64'(b.elem));
                        chk("beat_last", 64'(ifc.ea_last), 64'(b.last));
                    end
                    if (got_n < MAX_VL) begin
                        got_ea[got_n]   = ifc.ea;
                        got_elem[got_n] = int'(ifc.ea_elem);
                    end
                    if (got_n == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    got_n++;
                end
                if (ifc.idx_req) begin
                    idx_req_cyc++;
                    if (ifc.idx_valid) begin
                        if (exp_idx_q.size() == 0) begin
                            tests++;
                            failed++;
                            $display("FAIL extra_idx: got idx_elem %0d, expected no request", ifc.idx_elem);
                        end else begin
                            chk("idx_elem", 64'(ifc.idx_elem), 64'(exp_idx_q.pop_front()));
                        end
                    end
                end
                if (ifc.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_fault", 64'(ifc.fault), 64'(exp_fault));
                    chk("beats_left", 64'(exp_q.size()), 64'd0);
                end
            end
        end
    end

    // Index responder: returns idx_val[elem] on the IDX_LAT-th cycle of a request.
    initial begin : idx_resp
        int cnt;
        cnt = 0;
        ifc.idx_valid = 1'b0;
        ifc.idx_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ifc.idx_req && !ifc.idx_valid) begin
                cnt++;
                if (cnt >= IDX_LAT) begin
                    ifc.idx_valid = 1'b1;
                    ifc.idx_data  = idx_val[ifc.idx_elem[5:0]];
                    cnt = 0;
                end
            end else begin
                ifc.idx_valid = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] mode, input logic [31:0] base, input logic [31:0] disp,
                        input logic [31:0] stride, input logic [1:0] esz, input logic [1:0] sc,
                        input int vl, input logic [63:0] mask,
                        input logic [31:0] lo, input logic [31:0] hi);
        int w;
        w = 0;
        while (!ifc.cmd_ready && w < 100) begin
            tick();
            w++;
        end
        if (!ifc.cmd_ready) begin
            tests++;
            failed++;
            $display("FAIL ready_timeout: got cmd_ready 0, expected 1");
        end
        build_exp(mode, base, disp, stride, esz, sc, vl, mask, lo, hi);
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_mode   = mode;
        ifc.cmd_base   = base;
        ifc.cmd_disp   = disp;
        ifc.cmd_stride = stride;
        ifc.cmd_esz    = esz;
        ifc.cmd_sc     = sc;
        ifc.cmd_vl     = 7'(vl);
        ifc.cmd_mask   = mask;
        ifc.cmd_lo     = lo;
        ifc.cmd_hi     = hi;
        acc_cyc = cyc + 1;
        tick();
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int w;
        d0 = done_cnt;
        w = 0;
        while (done_cnt == d0 && w < budget) begin
            tick();
            w++;
        end
        if (done_cnt == d0) begin
            tests++;
            failed++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
        end
    endtask

    initial begin : main
        int d0;
        int w;
        int exp_n;
        logic [31:0] all_hi;
        all_hi = 32'hFFFF_FFFF;
        rst_n          = 1'b0;
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_mode   = 2'd0;
        ifc.cmd_base   = '0;
        ifc.cmd_disp   = '0;
        ifc.cmd_stride = '0;
        ifc.cmd_esz    = 2'd0;
        ifc.cmd_sc     = 2'd0;
        ifc.cmd_vl     = '0;
        ifc.cmd_mask   = '0;
        ifc.cmd_lo     = '0;
        ifc.cmd_hi     = '0;
        ifc.ea_ready   = 1'b0;
        ifc.abort      = 1'b0;
        for (int k = 0; k < MAX_VL; k++) idx_val[k] = 64'd0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_ea_valid", 64'(ifc.ea_valid), 64'd0);
        chk("rst_done", 64'(ifc.done), 64'd0);
        chk("rst_idx_req", 64'(ifc.idx_req), 64'd0);
        chk("rst_fault", 64'(ifc.fault), 64'd0);
        chk("rst_ea", 64'(ifc.ea), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Unit stride, 4-byte elements.
        ifc.ea_ready = 1'b1;
        send(2'd1, 32'h1000, 32'h8, 32'h0, 2'd2, 2'd0, 4, 64'hF, 32'h0, all_hi);
        wait_done(60);
        chk("t1_count", 64'(got_n), 64'd4);
        chk("t1_ea0", 64'(got_ea[0]), 64'h1008);
        chk("t1_ea3", 64'(got_ea[3]), 64'h1014);
        chk("t1_first_cyc", 64'(first_cyc), 64'(acc_cyc));
        chk("t1_done_after_last", 64'(done_cyc), 64'(last_cyc + 1));

        // Negative stride with a hole in the mask.
        send(2'd2, 32'h2000, 32'h0, 32'hFFFF_FFF0, 2'd0, 2'd0, 3, 64'b101, 32'h0, all_hi);
        wait_done(60);
        chk("t2_count", 64'(got_n), 64'd2);
        chk("t2_ea0", 64'(got_ea[0]), 64'h2000);
        chk("t2_ea1", 64'(got_ea[1]), 64'h1FE0);
        chk("t2_elem1", 64'(got_elem[1]), 64'd2);

        // Indexed, one element, scale by 8.
        idx_val[0] = 64'd5;
        send(2'd3, 32'h3000, 32'h10, 32'h0, 2'd0, 2'd3, 1, 64'h1, 32'h0, all_hi);
        wait_done(60);
        chk("t3_ea", 64'(got_ea[0]), 64'h3038);
        chk("t3_idx_req_cycles", 64'(idx_req_cyc), 64'd3);

        // Indexed with a negative index.
        idx_val[0] = 64'd7;
        idx_val[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        send(2'd3, 32'h100, 32'h0, 32'h0, 2'd0, 2'd1, 2, 64'h3, 32'h0, all_hi);
        wait_done(80);
        chk("t4_ea0", 64'(got_ea[0]), 64'h10E);
        chk("t4_ea1", 64'(got_ea[1]), 64'hFC);

        // Scalar ignores vl and mask.
        send(2'd0, 32'h4000, 32'h20, 32'h0, 2'd0, 2'd0, 0, 64'h0, 32'h0, all_hi);
        wait_done(20);
        chk("t5_count", 64'(got_n), 64'd1);
        chk("t5_ea", 64'(got_ea[0]), 64'h4020);
        chk("t5_first_cyc", 64'(first_cyc), 64'(acc_cyc));

        // Empty commands complete at T+2 without beats.
        send(2'd1, 32'h5000, 32'h0, 32'h0, 2'd2, 2'd0, 0, 64'hF, 32'h0, all_hi);
        wait_done(20);
        chk("t6_vl0_done_cyc", 64'(done_cyc), 64'(acc_cyc + 1));
        chk("t6_vl0_count", 64'(got_n), 64'd0);
        send(2'd2, 32'h5000, 32'h0, 32'h4, 2'd0, 2'd0, 5, 64'h0, 32'h0, all_hi);
        wait_done(20);
        chk("t6_mask0_done_cyc", 64'(done_cyc), 64'(acc_cyc + 1));
        chk("t6_mask0_count", 64'(got_n), 64'd0);

        // Oversized vl clamps to MAX_VL.
        send(2'd1, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 100, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, all_hi);
        wait_done(400);
        chk("t7_count", 64'(got_n), 64'd64);
        chk("t7_last_elem", 64'(got_elem[63]), 64'd63);

        // Back-pressure: hold ready low for five cycles on the first beat.
        ifc.ea_ready = 1'b0;
        send(2'd1, 32'h6000, 32'h0, 32'h0, 2'd0, 2'd0, 3, 64'h7, 32'h0, all_hi);
        w = 0;
        while (!ifc.ea_valid && w < 20) begin
            tick();
            w++;
        end
        chk("t8_valid_seen", 64'(ifc.ea_valid), 64'd1);
        repeat (5) tick();
        ifc.ea_ready = 1'b1;
        wait_done(40);
        chk("t8_count", 64'(got_n), 64'd3);

        // Abort while element 2 is pending.
        send(2'd1, 32'h7000, 32'h0, 32'h0, 2'd2, 2'd0, 8, 64'hFF, 32'h0, all_hi);
        w = 0;
        while (!(ifc.ea_valid && ifc.ea_elem == 7'd2) && w < 40) begin
            tick();
            w++;
        end
        chk("t9_elem2_seen", 64'(ifc.ea_elem), 64'd2);
        d0 = done_cnt;
        ifc.ea_ready = 1'b0;
        ifc.abort    = 1'b1;
        exp_q.delete();
        tick();
        ifc.abort = 1'b0;
        @(negedge clk);
        chk("t9_busy", 64'(ifc.busy), 64'd0);
        chk("t9_cmd_ready", 64'(ifc.cmd_ready), 64'd1);
        chk("t9_ea_valid", 64'(ifc.ea_valid), 64'd0);
        repeat (3) tick();
        chk("t9_no_done", 64'(done_cnt), 64'(d0));
        chk("t9_count", 64'(got_n), 64'd2);
        ifc.ea_ready = 1'b1;
        send(2'd1, 32'h7100, 32'h0, 32'h0, 2'd0, 2'd0, 2, 64'h3, 32'h0, all_hi);
        wait_done(30);
        chk("t9_new_count", 64'(got_n), 64'd2);
        chk("t9_new_ea1", 64'(got_ea[1]), 64'h7101);

        // Abort beats cmd_valid in IDLE.
        build_exp(2'd1, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 0, 64'h0, 32'h0, all_hi);
        d0 = done_cnt;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_mode  = 2'd1;
        ifc.cmd_vl    = 7'd1;
        ifc.cmd_mask  = 64'h1;
        ifc.abort     = 1'b1;
        tick();
        ifc.cmd_valid = 1'b0;
        ifc.abort     = 1'b0;
        @(negedge clk);
        chk("t10_busy", 64'(ifc.busy), 64'd0);
        repeat (3) tick();
        chk("t10_no_done", 64'(done_cnt), 64'(d0));

        // Bounds window [0, 0x100F] over a 4-byte unit-stride run.
        send(2'd1, 32'h1008, 32'h0, 32'h0, 2'd2, 2'd0, 4, 64'hF, 32'h0, 32'h100F);
        wait_done(60);
        repeat (2) tick();
`ifdef THOR_VAGEN_BOUNDS_CHK_EN
        exp_n = 2;
        chk("t11_fault_held", 64'(ifc.fault), 64'd1);
`else
        exp_n = 4;
        chk("t11_fault_tied", 64'(ifc.fault), 64'd0);
`endif
        chk("t11_count", 64'(got_n), 64'(exp_n));
        send(2'd0, 32'h1000, 32'h0, 32'h0, 2'd0, 2'd0, 1, 64'h1, 32'h0, all_hi);
        @(negedge clk);
        chk("t11_fault_cleared", 64'(ifc.fault), 64'd0);
        wait_done(20);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
